// File: rtl/hamsa_l0_pkg.sv
// hamsa L0 line cache: shared types and defaults.
// State enum, parameter defaults and tag width helper.
package hamsa_l0_pkg;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_e;

  localparam int ADDR_W_DEF          = 32;
  localparam int LINE_BYTES_LOG2_DEF = 4;
  localparam int SETS_LOG2_DEF       = 2;
  localparam int WAYS_DEF            = 2;
  localparam int NUM_PORTS_DEF       = 3;

  function automatic int tag_w(
    input int addr_w,
    input int sets_log2,
    input int line_log2
  );
    return addr_w - sets_log2 - line_log2;
  endfunction

endpackage

// File: rtl/hamsa_l0_way_select.sv
// hamsa L0 refill victim choice for one set:
// existing tag first, then lowest invalid way, then round-robin.
module hamsa_l0_way_select #(
  parameter int WAYS   = 2,
  parameter int WIDX_W = 1
) (
  input  logic [WAYS-1:0]   valid,
  input  logic [WAYS-1:0]   dup,
  input  logic [WIDX_W-1:0] rr,
  output logic [WIDX_W-1:0] way,
  output logic              evict
);

  always_comb begin
    way   = rr;
    evict = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        way   = WIDX_W'(w);
        evict = 1'b0;
      end
    end
    // a matching tag outranks any free way
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (dup[w]) begin
        way   = WIDX_W'(w);
        evict = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hamsa_l0_cache_nway.sv
// hamsa L0 N-way line cache: multi-port combinational match,
// refill, single-line invalidate and swept flush.
module hamsa_l0_cache_nway
  import hamsa_l0_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int LINE_BYTES_LOG2 = LINE_BYTES_LOG2_DEF,
  parameter int SETS_LOG2       = SETS_LOG2_DEF,
  parameter int WAYS            = WAYS_DEF,
  parameter int NUM_PORTS       = NUM_PORTS_DEF,
  localparam int LINE_W = 8 * (2 ** LINE_BYTES_LOG2)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_W-1:0]                  wr_addr_i,
  input  logic [LINE_W-1:0]                  wr_data_i,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  input  logic [ADDR_W-1:0]                  inval_addr_i,
  input  logic                               inval_valid_i,
  input  logic                               flush_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   match_addr_i,
  output logic [NUM_PORTS-1:0]               match_hit_o,
  output logic [NUM_PORTS-1:0][LINE_W-1:0]   match_data_o,
  output logic                               busy_o,
  output logic [15:0]                        hit_cnt_o
);

  localparam int SETS   = 2 ** SETS_LOG2;
  localparam int TAG_W  = tag_w(ADDR_W, SETS_LOG2, LINE_BYTES_LOG2);
  localparam int WIDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
    $error("hamsa_l0_cache_nway: WAYS must be 1, 2 or 4");
  end
  if (SETS_LOG2 + LINE_BYTES_LOG2 >= ADDR_W) begin : g_bad_split
    $error("hamsa_l0_cache_nway: no tag bits left in address");
  end
  if (SETS_LOG2 < 1) begin : g_bad_sets
    $error("hamsa_l0_cache_nway: SETS_LOG2 must be at least 1");
  end

  function automatic logic [SETS_LOG2-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return SETS_LOG2'(a >> LINE_BYTES_LOG2);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (LINE_BYTES_LOG2 + SETS_LOG2));
  endfunction

  state_e                         state_q, state_d;
  logic [SETS_LOG2-1:0]           cnt_q, cnt_d;
  logic [15:0]                    hit_cnt_q, hit_cnt_d;
  logic [SETS-1:0][WAYS-1:0]      valid_q;
  logic [SETS-1:0][WIDX_W-1:0]    rr_q;
  logic [TAG_W-1:0]               tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]              data_q [SETS][WAYS];

  logic                 idle;
  logic [SETS_LOG2-1:0] wr_idx, inv_idx;
  logic [TAG_W-1:0]     wr_tag, inv_tag;
  logic [WAYS-1:0]      wr_dup, inv_hit;
  logic [WIDX_W-1:0]    wr_way, rr_next;
  logic                 wr_evict, wr_fire, inv_fire, collide, wr_do;
  logic [16:0]          hit_sum;

  assign idle       = (state_q == S_IDLE);
  assign wr_ready_o = idle && !flush_i;
  assign busy_o     = (state_q == S_FLUSH);
  assign hit_cnt_o  = hit_cnt_q;

  assign wr_idx  = idx_of(wr_addr_i);
  assign wr_tag  = tag_of(wr_addr_i);
  assign inv_idx = idx_of(inval_addr_i);
  assign inv_tag = tag_of(inval_addr_i);

  assign wr_fire  = wr_valid_i && wr_ready_o;
  assign inv_fire = inval_valid_i && wr_ready_o;
  // same line refilled and invalidated together: the invalidate wins
  assign collide  = wr_fire && inv_fire &&
                    (wr_idx == inv_idx) && (wr_tag == inv_tag);
  assign wr_do    = wr_fire && !collide;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      wr_dup[w]  = valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag);
      inv_hit[w] = valid_q[inv_idx][w] && (tag_q[inv_idx][w] == inv_tag);
    end
  end

  hamsa_l0_way_select #(
    .WAYS  (WAYS),
    .WIDX_W(WIDX_W)
  ) u_way_select (
    .valid(valid_q[wr_idx]),
    .dup  (wr_dup),
    .rr   (rr_q[wr_idx]),
    .way  (wr_way),
    .evict(wr_evict)
  );

  assign rr_next = (rr_q[wr_idx] == WIDX_W'(WAYS - 1)) ?
                   '0 : rr_q[wr_idx] + 1'b1;

  always_comb begin
    match_hit_o  = '0;
    match_data_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[idx_of(match_addr_i[p])][w] &&
            tag_q[idx_of(match_addr_i[p])][w] == tag_of(match_addr_i[p])) begin
          match_hit_o[p]  = idle && !flush_i;
          match_data_o[p] = data_q[idx_of(match_addr_i[p])][w];
        end
      end
    end
  end

  always_comb begin
    hit_sum = {1'b0, hit_cnt_q};
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit_sum = hit_sum + 17'(match_hit_o[p]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d   = S_FLUSH;
          cnt_d     = '0;
          hit_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (state_q == S_FLUSH) begin
      valid_q[cnt_q] <= '0;
    end else if (!flush_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (inv_fire && inv_hit[w]) valid_q[inv_idx][w] <= 1'b0;
      end
      // later assignment lets a refill win over an invalidate of its victim
      if (wr_do) begin
        valid_q[wr_idx][wr_way] <= 1'b1;
        if (wr_evict) rr_q[wr_idx] <= rr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      tag_q[wr_idx][wr_way]  <= wr_tag;
      data_q[wr_idx][wr_way] <= wr_data_i;
    end
  end

endmodule
